// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-ported scratch memory among NUM_REQ requesters
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      busy,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_read_adr,
  output logic [ADDR_W-1:0]         mem_write_adr,
  output logic [DATA_W-1:0]         mem_in_data,
  input  logic [DATA_W-1:0]         mem_out_data
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] last_grant, gnt, cur;
  logic gnt_any;
  logic [CW-1:0] cnt;
  // Scan downward in distance so the requester closest after last_grant wins.
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int j;
      j = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[j]) begin
        gnt = IW'(j);
        gnt_any = 1'b1;
      end
    end
  end
  assign req_ready = (rst_n && state == IDLE && gnt_any) ? NUM_REQ'(1) << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      cur <= '0;
      cnt <= '0;
      busy <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_read_adr <= '0;
      mem_write_adr <= '0;
      mem_in_data <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          state <= ISSUE;
          busy <= 1'b1;
          cur <= gnt;
          last_grant <= gnt;
          mem_read <= !req_write[gnt];
          mem_write <= req_write[gnt];
          if (req_write[gnt]) begin
            mem_write_adr <= req_addr[gnt*ADDR_W +: ADDR_W];
            mem_in_data <= req_wdata[gnt*DATA_W +: DATA_W];
          end else
            mem_read_adr <= req_addr[gnt*ADDR_W +: ADDR_W];
        end
        ISSUE: begin
          mem_read <= 1'b0;
          mem_write <= 1'b0;
          mem_read_adr <= '0;
          mem_write_adr <= '0;
          mem_in_data <= '0;
          cnt <= '0;
          state <= mem_write ? RESP : WAIT;
          resp_valid <= mem_write ? NUM_REQ'(1) << cur : '0;
        end
        WAIT: if (cnt == CW'(MEM_LAT - 1)) begin
          resp_rdata <= mem_out_data;
          resp_valid <= NUM_REQ'(1) << cur;
          state <= RESP;
        end else
          cnt <= cnt + 1'b1;
        RESP: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, write/read data path and async reset
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst_n;
  logic [3:0] rv, rw, rv3, rw3;
  logic [31:0] ra, ra3;
  logic [127:0] rd, rd3;
  logic [3:0] req_ready, resp_valid, req_ready3, resp_valid3;
  logic [31:0] resp_rdata, resp_rdata3, mem_in_data, mem_in_data3, mem_out_data, mem_out_data3;
  logic busy, mem_read, mem_write, busy3, mem_read3, mem_write3;
  logic [7:0] mem_read_adr, mem_write_adr, mem_read_adr3, mem_write_adr3;
  logic [31:0] mem [256];
  logic [31:0] mem3 [256];
  logic [31:0] p3 [3];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_write(rw), .req_addr(ra), .req_wdata(rd),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_adr(mem_read_adr),
    .mem_write_adr(mem_write_adr), .mem_in_data(mem_in_data), .mem_out_data(mem_out_data));
  mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_write(rw3), .req_addr(ra3), .req_wdata(rd3),
    .req_ready(req_ready3), .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .busy(busy3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_read_adr(mem_read_adr3),
    .mem_write_adr(mem_write_adr3), .mem_in_data(mem_in_data3), .mem_out_data(mem_out_data3));
  // Memory models: 1-cycle registered read for dut, 3-stage read pipeline for dut3.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 32'h0;
        mem3[i] <= 32'h0;
      end
      mem[5] <= 32'hDEADBEEF;
      mem3[16] <= 32'hCAFEF00D;
    end else begin
      if (mem_write) mem[mem_write_adr] <= mem_in_data;
      if (mem_write3) mem3[mem_write_adr3] <= mem_in_data3;
    end
    mem_out_data <= mem[mem_read_adr];
    p3[0] <= mem3[mem_read_adr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_out_data3 = p3[2];
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    total++; if (req_ready !== 4'b0) $display("FAIL rst_ready got %b exp 0000", req_ready); else passed++;
    total++; if (resp_valid !== 4'b0) $display("FAIL rst_resp_valid got %b exp 0000", resp_valid); else passed++;
    total++; if ({busy, mem_read, mem_write} !== 3'b0) $display("FAIL rst_strobes got %b exp 000", {busy, mem_read, mem_write}); else passed++;
    total++; if ({mem_read_adr, mem_write_adr, mem_in_data, resp_rdata} !== 80'h0) $display("FAIL rst_data got %h exp 0", {mem_read_adr, mem_write_adr, mem_in_data, resp_rdata}); else passed++;
  endtask
  task automatic test_drop();
    rv = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL drop_ready got %b exp 0001", req_ready); else passed++;
    rv = 4'b0000; #1;
    step();
    total++; if (busy !== 1'b0) $display("FAIL drop_busy got %b exp 0", busy); else passed++;
  endtask
  task automatic test_read();
    rv = 4'b0010; rw = 4'b0; ra[15:8] = 8'h05; #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL rd_ready got %b exp 0010", req_ready); else passed++;
    step(); rv = 4'b0;
    total++; if ({mem_read, mem_write, mem_read_adr} !== {2'b10, 8'h05}) $display("FAIL rd_issue got %b%b %h exp 10 05", mem_read, mem_write, mem_read_adr); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rd_busy got %b exp 1", busy); else passed++;
    step();
    total++; if ({mem_read, resp_valid} !== 5'b0) $display("FAIL rd_wait got %b exp 00000", {mem_read, resp_valid}); else passed++;
    step();
    total++; if (resp_valid !== 4'b0010) $display("FAIL rd_resp got %b exp 0010", resp_valid); else passed++;
    total++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h exp deadbeef", resp_rdata); else passed++;
    step();
    total++; if ({busy, resp_valid} !== 5'b0) $display("FAIL rd_idle got %b exp 00000", {busy, resp_valid}); else passed++;
  endtask
  task automatic test_write_read();
    rv = 4'b0100; rw = 4'b0100; ra[23:16] = 8'h03; rd[95:64] = 32'h12345678; #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL wr_ready got %b exp 0100", req_ready); else passed++;
    step(); rv = 4'b0;
    total++; if ({mem_read, mem_write, mem_write_adr, mem_in_data} !== {2'b01, 8'h03, 32'h12345678}) $display("FAIL wr_issue got %b%b %h %h exp 01 03 12345678", mem_read, mem_write, mem_write_adr, mem_in_data); else passed++;
    step();
    total++; if (resp_valid !== 4'b0100) $display("FAIL wr_resp got %b exp 0100", resp_valid); else passed++;
    total++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL wr_rdata_hold got %h exp deadbeef", resp_rdata); else passed++;
    step();
    rv = 4'b0100; rw = 4'b0; #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL rb_ready got %b exp 0100", req_ready); else passed++;
    step(); rv = 4'b0;
    step(); step();
    total++; if ({resp_valid, resp_rdata} !== {4'b0100, 32'h12345678}) $display("FAIL rb_resp got %b %h exp 0100 12345678", resp_valid, resp_rdata); else passed++;
    step();
  endtask
  task automatic test_round_robin();
    logic [3:0] e;
    rv = 4'hF; rw = 4'b0;
    rst_n = 1'b0; #3; rst_n = 1'b1; #1;
    for (int t = 0; t < 5; t++) begin
      e = 4'b0001 << (t % 4);
      total++; if ({req_ready, busy} !== {e, 1'b0}) $display("FAIL rr_grant%0d got %b %b exp %b 0", t, req_ready, busy, e); else passed++;
      for (int c = 1; c < 4; c++) begin
        step();
        total++; if ({req_ready, busy} !== 5'b00001) $display("FAIL rr_busy%0d_%0d got %b %b exp 0000 1", t, c, req_ready, busy); else passed++;
        total++; if (resp_valid !== (c == 3 ? e : 4'b0)) $display("FAIL rr_resp%0d_%0d got %b exp %b", t, c, resp_valid, c == 3 ? e : 4'b0); else passed++;
      end
      step();
    end
  endtask
  task automatic test_wrap();
    rv = 4'b1001; #1;
    total++; if (req_ready !== 4'b1000) $display("FAIL wrap_first got %b exp 1000", req_ready); else passed++;
    repeat (4) step();
    total++; if (req_ready !== 4'b0001) $display("FAIL wrap_second got %b exp 0001", req_ready); else passed++;
    step(); rv = 4'b0;
    repeat (3) step();
  endtask
  task automatic test_reset_mid();
    rv = 4'b0100; rw = 4'b0; ra[23:16] = 8'h05; #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL rm_ready got %b exp 0100", req_ready); else passed++;
    step(); rv = 4'b0;
    step();
    total++; if (busy !== 1'b1) $display("FAIL rm_wait_busy got %b exp 1", busy); else passed++;
    #1 rst_n = 1'b0; #1;
    total++; if ({busy, mem_read, mem_write, resp_valid} !== 7'b0) $display("FAIL rm_async got %b exp 0000000", {busy, mem_read, mem_write, resp_valid}); else passed++;
    step(); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if ({busy, resp_valid} !== 5'b0) $display("FAIL rm_noresp%0d got %b exp 00000", c, {busy, resp_valid}); else passed++;
    end
    rv = 4'hF; #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL rm_prio got %b exp 0001", req_ready); else passed++;
    step(); rv = 4'b0;
    repeat (3) step();
  endtask
  task automatic test_lat3();
    int n;
    rv3 = 4'b0001; rw3 = 4'b0; ra3[7:0] = 8'h10; #1;
    total++; if (req_ready3 !== 4'b0001) $display("FAIL l3_ready got %b exp 0001", req_ready3); else passed++;
    step(); rv3 = 4'b0;
    n = int'(mem_read3);
    total++; if ({mem_read3, mem_read_adr3} !== {1'b1, 8'h10}) $display("FAIL l3_issue got %b %h exp 1 10", mem_read3, mem_read_adr3); else passed++;
    for (int c = 2; c < 5; c++) begin
      step();
      n += int'(mem_read3);
      total++; if (resp_valid3 !== 4'b0) $display("FAIL l3_early%0d got %b exp 0000", c, resp_valid3); else passed++;
    end
    step();
    n += int'(mem_read3);
    total++; if ({resp_valid3, resp_rdata3} !== {4'b0001, 32'hCAFEF00D}) $display("FAIL l3_resp got %b %h exp 0001 cafef00d", resp_valid3, resp_rdata3); else passed++;
    total++; if (n !== 1) $display("FAIL l3_strobe_count got %0d exp 1", n); else passed++;
    step();
  endtask
  initial begin
    rst_n = 1'b0; rv = '0; rw = '0; ra = '0; rd = '0; rv3 = '0; rw3 = '0; ra3 = '0; rd3 = '0;
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    rst_n = 1'b1; #1;
    test_drop();
    test_read();
    test_write_read();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_lat3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
